pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage sequencer that owns the program counter and drives the instruction-memory request port. It issues one outstanding fetch at a time, redirects on traps and branches, and holds under pipeline pause. It delivers a (pc, instruction) pair to decode through a registered output slot backed by a one-entry skid buffer.

## Interface
- START_ADDR, default `CPU_START_ADDR`: PC loaded on reset.
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pause  in  1  decode stall; decode does not consume `if_*` this cycle.
- trap_valid  in  1  trap redirect request; highest priority.
- trap_addr  in  `XLEN_WIDTH`  trap target.
- redirect_valid  in  1  branch/jump redirect from execute.
- redirect_addr  in  `XLEN_WIDTH`  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  `XLEN_WIDTH`  fetch address; equals `pc`.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- pc  out  `XLEN_WIDTH`  next address to fetch.
- if_valid  out  1  instruction slot occupied.
- if_pc  out  `XLEN_WIDTH`  address of the slot instruction.
- if_inst  out  32  slot instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. `imem_req` = (state==REQ); no other source drives it.
- IDLE: exactly one cycle after reset, then REQ.
- REQ: on `imem_gnt`: `pend_pc <= pc`, `pc <= pc + 4` (wraps modulo 2^XLEN), go to WAIT. Without `imem_gnt`, `imem_req` and `imem_addr` stay stable.
- WAIT: on `imem_rvalid`, the slot is free when `!if_valid || !pause`.
  - Slot free: load `if_pc/if_inst` from `pend_pc/imem_rdata`, set `if_valid`, go to REQ.
  - Slot busy: capture into the skid buffer, go to HOLD.
- HOLD: no request. When `!pause`, move the skid buffer into the slot and go to REQ.
- Slot consumption: on any edge with `if_valid && !pause` and no new load, clear `if_valid`.
- Redirect: target = `trap_addr` if `trap_valid`, else `redirect_addr`. Applies in any state, regardless of `pause`.
  - `pc <= target`; `if_valid` and the skid buffer are cleared at the same edge.
  - If a response is outstanding, go to DROP; otherwise go to REQ. A response is outstanding in WAIT, or in REQ with `imem_gnt` the same cycle.
  - Redirect in DROP: update `pc` and stay in DROP.
- DROP: the next `imem_rvalid` is discarded and never reaches the slot; then go to REQ.
- `imem_rvalid` outside WAIT/DROP is ignored.

## Timing
- Reset values: `pc`=START_ADDR, state=IDLE, `imem_req`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0, skid empty, `pend_pc`=0.
- First `imem_req` is at cycle 2 after `rst` falls: IDLE occupies cycle 1.
- Latency: with `imem_gnt` in cycle N and `imem_rvalid` in cycle N+1, `if_valid` rises at the edge ending N+1. The next request is at N+2, giving a steady state of 1 instruction per 2 cycles for a single-cycle memory.
- Redirect latency: the new target appears on `imem_addr` the cycle after the redirect, or after the dropped response when one is outstanding.
- `rst` mid-fetch: the outstanding response is lost. Memory must tolerate an abandoned request.

## Configuration
- `PC_FETCH_MISALIGN_TRAP_EN`: adds outputs `misalign_valid` (1) and `misalign_addr` (`XLEN_WIDTH`).
  - A redirect target with bits[1:0]!=0 is not loaded into `pc`.
  - Instead, `misalign_valid` pulses for 1 cycle with the target, and state goes to HOLD with an empty skid (no fetch) until the next trap redirect.
  - Trap targets are never checked.
- Without the macro: the ports are absent, bits[1:0] of every target are forced to 0, and fetch proceeds.

## Test plan
- Reset, START_ADDR=0x8000_0000, `imem_gnt`=1, `imem_rvalid` 1 cycle after grant, rdata=addr^0xFFFF_FFFF -> if_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 with matching if_inst, `imem_req` first high at cycle 2.
- `pause`=1 for 5 cycles with slot full while response 0x8000_0004 returns -> state HOLD, `imem_req`=0. `if_pc` holds 0x8000_0000 until pause drops, then 0x8000_0004 next cycle.
- redirect_valid with 0x8000_0100 during WAIT -> pending response dropped, `if_valid`=0, next `imem_addr`=0x8000_0100.
- trap_valid (0x8000_0200) and redirect_valid (0x8000_0300) same cycle -> `pc`=0x8000_0200.
- `pc`=0xFFFF_FFFC granted -> `pc` wraps to 0x0000_0000.
- Macro on, redirect to 0x8000_0102 -> `misalign_valid`=1 for 1 cycle with `misalign_addr`=0x8000_0102, no fetch until trap to 0x8000_0400. Macro off -> fetch at 0x8000_0100.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one instruction fetch at a time and hands (pc, inst) to decode through a registered slot with a one-entry skid buffer.
// Optional feature: define PC_FETCH_MISALIGN_TRAP_EN to report misaligned redirect targets instead of silently aligning them.
`ifndef XLEN_WIDTH
`define XLEN_WIDTH 32
`endif
`ifndef CPU_START_ADDR
`define CPU_START_ADDR {`XLEN_WIDTH{1'b0}}
`endif

module pc_fetch_ctrl #(
  parameter logic [`XLEN_WIDTH-1:0] START_ADDR = `CPU_START_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause,
  input  logic                   trap_valid,
  input  logic [`XLEN_WIDTH-1:0] trap_addr,
  input  logic                   redirect_valid,
  input  logic [`XLEN_WIDTH-1:0] redirect_addr,
  output logic                   imem_req,
  output logic [`XLEN_WIDTH-1:0] imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic [`XLEN_WIDTH-1:0] pc,
  output logic                   if_valid,
  output logic [`XLEN_WIDTH-1:0] if_pc,
  output logic [31:0]            if_inst
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_valid,
  output logic [`XLEN_WIDTH-1:0] misalign_addr
`endif
);

  localparam int unsigned XW = `XLEN_WIDTH;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   pc_q, pc_d;
  logic [XW-1:0]   pend_pc_q, pend_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XW-1:0]   if_pc_q, if_pc_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic [XW-1:0]   skid_pc_q, skid_pc_d;
  logic [31:0]     skid_inst_q, skid_inst_d;

  logic            redir_en;
  logic [XW-1:0]   target;
  logic            outstanding;
  logic            slot_load;
  logic            hold_release;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic            halt_q, halt_d;
  logic            misalign_valid_q, misalign_valid_d;
  logic [XW-1:0]   misalign_addr_q, misalign_addr_d;
  logic            bad_align;

  // While halted on a bad target only a trap may restart fetch.
  assign redir_en     = trap_valid || (redirect_valid && !halt_q);
  assign target       = trap_valid ? trap_addr : redirect_addr;
  assign bad_align    = !trap_valid && (target[1:0] != 2'b00);
  assign hold_release = !halt_q && !pause;
`else
  assign redir_en     = trap_valid || redirect_valid;
  assign target       = (trap_valid ? trap_addr : redirect_addr) & ~XW'(3);
  assign hold_release = !pause;
`endif

  // A response is still in flight if it was granted this cycle or is awaited but not arriving now.
  assign outstanding = (state_q == REQ  && imem_gnt) ||
                       (state_q == WAIT && !imem_rvalid) ||
                       (state_q == DROP && !imem_rvalid);

  // NOTE: every value driven here gets a default first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    slot_load   = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    halt_d           = halt_q;
    misalign_valid_d = 1'b0;
    misalign_addr_d  = misalign_addr_q;
`endif

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + XW'(4);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (!if_valid_q || !pause) begin
            if_pc_d   = pend_pc_q;
            if_inst_d = imem_rdata;
            slot_load = 1'b1;
            state_d   = REQ;
          end else begin
            skid_pc_d   = pend_pc_q;
            skid_inst_d = imem_rdata;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_release) begin
          if_pc_d   = skid_pc_q;
          if_inst_d = skid_inst_q;
          slot_load = 1'b1;
          state_d   = REQ;
        end
      end
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (slot_load)                if_valid_d = 1'b1;
    else if (if_valid_q && !pause) if_valid_d = 1'b0;

    // Redirects override everything above, whatever the stall state.
    if (redir_en) begin
      if_valid_d  = 1'b0;
      skid_pc_d   = '0;
      skid_inst_d = '0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      if (bad_align) begin
        pc_d             = pc_q;
        misalign_valid_d = 1'b1;
        misalign_addr_d  = target;
        halt_d           = 1'b1;
        state_d          = HOLD;
      end else begin
        pc_d    = target;
        halt_d  = 1'b0;
        state_d = outstanding ? DROP : REQ;
      end
`else
      pc_d    = target;
      state_d = outstanding ? DROP : REQ;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= START_ADDR;
      pend_pc_q   <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q           <= 1'b0;
      misalign_valid_q <= 1'b0;
      misalign_addr_q  <= '0;
    end else begin
      halt_q           <= halt_d;
      misalign_valid_q <= misalign_valid_d;
      misalign_addr_q  <= misalign_addr_d;
    end
  end

  assign misalign_valid = misalign_valid_q;
  assign misalign_addr  = misalign_addr_q;
`endif

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: cycle-exact scenarios with a small latency-programmable instruction memory.
// Build with PC_FETCH_MISALIGN_TRAP_EN defined to exercise the misaligned-target reporting path.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic        misalign_valid;
  logic [31:0] misalign_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  pc_fetch_ctrl #(.START_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .trap_valid(trap_valid), .trap_addr(trap_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    , .misalign_valid(misalign_valid), .misalign_addr(misalign_addr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: grants whenever asked, answers mem_lat cycles after the grant with ~addr.
  int          m_cnt;
  logic        m_pend;
  logic        m_gseen;
  logic [31:0] m_gaddr;
  logic [31:0] m_paddr;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    m_pend      = 1'b0;
    m_cnt       = 0;
    m_paddr     = '0;
    forever begin
      @(negedge clk); #1;
      m_gseen = imem_req && imem_gnt;
      m_gaddr = imem_addr;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (rst) m_pend = 1'b0;
      else begin
        if (m_gseen) begin
          m_pend  = 1'b1;
          m_cnt   = mem_lat;
          m_paddr = m_gaddr;
        end
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = m_paddr ^ 32'hFFFF_FFFF;
            m_pend      = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the mid-point of cycle 1 after reset release (state IDLE).
  task automatic do_reset(input int lat);
    @(negedge clk);
    mem_lat = lat;
    rst = 1'b1; pause = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0;
    go(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    n_checks++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc act=%h exp=%h", pc, 32'h8000_0000); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req act=%b exp=0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid act=%b exp=0", if_valid); end
    n_checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_slot act=%h/%h exp=0/0", if_pc, if_inst); end
  endtask

  task automatic test_fetch_seq();
    logic        exp_req   [1:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        exp_valid [1:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_addr  [1:8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004,
                                     32'h8000_0008, 32'h8000_0008, 32'h8000_000C, 32'h8000_000C};
    logic [31:0] exp_pc    [1:8] = '{32'h0, 32'h0, 32'h0, 32'h8000_0000,
                                     32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 32'h8000_0008};
    logic [31:0] e_inst;
    do_reset(1);
    for (int c = 1; c <= 8; c++) begin
      e_inst = (c >= 4) ? ~exp_pc[c] : 32'h0;
      n_checks++; if (imem_req !== exp_req[c]) begin n_fail++; $display("FAIL seq_req c%0d act=%b exp=%b", c, imem_req, exp_req[c]); end
      n_checks++; if (if_valid !== exp_valid[c]) begin n_fail++; $display("FAIL seq_valid c%0d act=%b exp=%b", c, if_valid, exp_valid[c]); end
      n_checks++; if (imem_addr !== exp_addr[c]) begin n_fail++; $display("FAIL seq_addr c%0d act=%h exp=%h", c, imem_addr, exp_addr[c]); end
      n_checks++; if (if_pc !== exp_pc[c] || if_inst !== e_inst) begin n_fail++; $display("FAIL seq_slot c%0d act=%h/%h exp=%h/%h", c, if_pc, if_inst, exp_pc[c], e_inst); end
      go(1);
    end
  endtask

  task automatic test_pause();
    do_reset(1);
    go(3);
    pause = 1'b1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL pause_c4 act=%b/%h exp=1/80000000", if_valid, if_pc); end
    go(2);
    for (int c = 6; c <= 8; c++) begin
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL pause_req c%0d act=%b exp=0", c, imem_req); end
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL pause_slot c%0d act=%b/%h exp=1/80000000", c, if_valid, if_pc); end
      go(1);
    end
    n_checks++; if (if_pc !== 32'h8000_0000 || imem_req !== 1'b0) begin n_fail++; $display("FAIL pause_c9 act=%h/%b exp=80000000/0", if_pc, imem_req); end
    pause = 1'b0;
    go(1);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0004 || if_inst !== 32'h7FFF_FFFB) begin n_fail++; $display("FAIL pause_release act=%b/%h/%h exp=1/80000004/7ffffffb", if_valid, if_pc, if_inst); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL pause_next_req act=%b/%h exp=1/80000008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset(3);
    go(5);
    pause = 1'b1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL rdw_slot act=%b/%h exp=1/80000000", if_valid, if_pc); end
    go(1);
    n_checks++; if (imem_req !== 1'b0 || imem_rvalid !== 1'b0) begin n_fail++; $display("FAIL rdw_wait act=%b/%b exp=0/0", imem_req, imem_rvalid); end
    redirect_valid = 1'b1; redirect_addr = 32'h8000_0100;
    go(1);
    redirect_valid = 1'b0; pause = 1'b0;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_clear act=%b exp=0", if_valid); end
    n_checks++; if (pc !== 32'h8000_0100 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_drop act=%h/%b exp=80000100/0", pc, imem_req); end
    go(2);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rdw_newreq act=%b/%h exp=1/80000100", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped_load act=%b exp=0", if_valid); end
    go(4);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0100 || if_inst !== 32'h7FFF_FEFF) begin n_fail++; $display("FAIL rdw_target act=%b/%h/%h exp=1/80000100/7ffffeff", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_trap_priority();
    do_reset(1);
    go(1);
    trap_valid = 1'b1; trap_addr = 32'h8000_0200;
    redirect_valid = 1'b1; redirect_addr = 32'h8000_0300;
    go(1);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'h8000_0200) begin n_fail++; $display("FAIL trap_prio_pc act=%h exp=80000200", pc); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL trap_prio_drop act=%b exp=0", imem_req); end
    go(1);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0200) begin n_fail++; $display("FAIL trap_prio_req act=%b/%h exp=1/80000200", imem_req, imem_addr); end
    go(2);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL trap_prio_slot act=%b/%h exp=1/80000200", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    go(1);
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req act=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
    go(1);
    n_checks++; if (pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc act=%h exp=00000000", pc); end
    go(1);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h0000_0003) begin n_fail++; $display("FAIL wrap_slot act=%b/%h/%h exp=1/fffffffc/00000003", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_misalign();
    do_reset(1);
    redirect_valid = 1'b1; redirect_addr = 32'h8000_0102;
    go(1);
    redirect_valid = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    n_checks++; if (misalign_valid !== 1'b1 || misalign_addr !== 32'h8000_0102) begin n_fail++; $display("FAIL mis_pulse act=%b/%h exp=1/80000102", misalign_valid, misalign_addr); end
    n_checks++; if (imem_req !== 1'b0 || pc !== 32'h8000_0000) begin n_fail++; $display("FAIL mis_nofetch act=%b/%h exp=0/80000000", imem_req, pc); end
    go(1);
    n_checks++; if (misalign_valid !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle act=%b exp=0", misalign_valid); end
    for (int c = 4; c <= 6; c++) begin
      go(1);
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_halt c%0d act=%b exp=0", c, imem_req); end
    end
    trap_valid = 1'b1; trap_addr = 32'h8000_0400;
    go(1);
    trap_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0400) begin n_fail++; $display("FAIL mis_trap_resume act=%b/%h exp=1/80000400", imem_req, imem_addr); end
`else
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL mis_align_req act=%b/%h exp=1/80000100", imem_req, imem_addr); end
    go(2);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL mis_align_slot act=%b/%h exp=1/80000100", if_valid, if_pc); end
`endif
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; imem_gnt = 1'b1;
    trap_valid = 1'b0; trap_addr = '0;
    redirect_valid = 1'b0; redirect_addr = '0;
    test_reset();
    test_fetch_seq();
    test_pause();
    test_redirect_wait();
    test_trap_priority();
    test_wrap();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
